// File: rtl/dac_word_sequencer_if.sv
// ----------------------------------------------------------------------------
// dac_word_sequencer_if
//   Write-port bundle between dac_word_sequencer and the fifo2shiftreg
//   serializer (DIN / WR_EN / FULL).
//   Signals:
//     din    16-bit command word {ch_index[3:0], code[11:0]}
//     wr_en  write strobe, one word per high cycle
//     full   FIFO full flag, fed back to the writer
//   Modports:
//     master  the sequencer side (drives din/wr_en, observes full)
//     slave   the FIFO side (observes din/wr_en, drives full)
// ----------------------------------------------------------------------------
interface dac_word_sequencer_if;
  logic [15:0] din;
  logic        wr_en;
  logic        full;

  modport master (output din, output wr_en, input  full);
  modport slave  (input  din, input  wr_en, output full);
endinterface

// File: rtl/dac_word_sequencer.sv
// ----------------------------------------------------------------------------
// dac_word_sequencer
//   Takes a parallel snapshot of NCH 12-bit DAC channel codes when START is
//   pulsed and writes them, one word per cycle, as {ch_index[3:0], code[11:0]}
//   into the write port of the fifo2shiftreg serializer (same clock domain).
//
//   Parameters:
//     NCH  number of channels, 1..16
//     DW   bits per channel code, fixed at 12
//   Ports:
//     clk_i        system clock (also the FIFO write clock)
//     rst_i        asynchronous active-high reset
//     cfg_data_i   channel codes, channel i in bits [i*12+11 : i*12]
//     start_i      one-cycle burst request, honoured only when idle
//     busy_o       high from the accepted START through the DONE cycle
//     done_o       one-cycle pulse in the cycle after the last write
//     fifo         write port to fifo2shiftreg (master modport)
//
//   Optional feature, macro SKIP_UNCHANGED_EN:
//     Remembers the last code written per channel and skips channels whose
//     snapshot code is unchanged. Each channel still takes exactly one cycle
//     when not stalled, so burst length in cycles stays NCH.
// ----------------------------------------------------------------------------
module dac_word_sequencer #(
  parameter int NCH = 4,
  parameter int DW  = 12
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NCH*DW-1:0]    cfg_data_i,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  dac_word_sequencer_if.master fifo
);

  typedef enum logic [1:0] {IDLE, WRITE, FIN} state_t;

  localparam logic [3:0] LastIdx = 4'(NCH - 1);

  state_t        state_q;
  logic [3:0]    index_q;
  logic [3:0]    index_d;
  logic [15:0]   din_q;
  logic          busy_q;
  logic          done_q;
  logic [DW-1:0] snap_q [NCH];

  logic [DW-1:0] curCode;
  logic [DW-1:0] nextCode;
  logic          pending;
  logic          wrEn;
  logic          advance;

  // Select the snapshot code for the current and the following channel with
  // a compare loop, so the index width never has to match the array depth.
  always_comb begin
    index_d  = index_q + 4'd1;
    curCode  = '0;
    nextCode = '0;
    for (int i = 0; i < NCH; i++) begin
      if (index_q == 4'(i)) curCode  = snap_q[i];
      if (index_d == 4'(i)) nextCode = snap_q[i];
    end
  end

`ifdef SKIP_UNCHANGED_EN
  logic [DW-1:0] shadow_q [NCH];
  logic [DW-1:0] curShadow;

  always_comb begin
    curShadow = '0;
    for (int i = 0; i < NCH; i++) begin
      if (index_q == 4'(i)) curShadow = shadow_q[i];
    end
  end

  // A channel only needs a word if its code differs from what was last sent.
  assign pending = (curCode != curShadow);

  // Shadow follows every word actually handed to the FIFO.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NCH; i++) shadow_q[i] <= '0;
    end else if (wrEn) begin
      for (int i = 0; i < NCH; i++) begin
        if (index_q == 4'(i)) shadow_q[i] <= curCode;
      end
    end
  end
`else
  assign pending = 1'b1;
`endif

  // Write strobe stays combinational on FULL so a write never lands on a full
  // FIFO; a skipped channel advances without touching the FIFO.
  assign wrEn    = (state_q == WRITE) && !fifo.full && pending;
  assign advance = (state_q == WRITE) && (wrEn || !pending);

  // Sequencer FSM. din_q always holds the word for index_q while in WRITE,
  // so on each advance it is preloaded with the next channel's word.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      index_q <= '0;
      din_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < NCH; i++) snap_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            for (int i = 0; i < NCH; i++) snap_q[i] <= cfg_data_i[i*DW +: DW];
            index_q <= '0;
            din_q   <= {4'd0, cfg_data_i[DW-1:0]};
            busy_q  <= 1'b1;
            state_q <= WRITE;
          end
        end
        WRITE: begin
          if (advance) begin
            if (index_q == LastIdx) begin
              done_q  <= 1'b1;
              state_q <= FIN;
            end else begin
              index_q <= index_d;
              din_q   <= {index_d, nextCode};
            end
          end
        end
        FIN: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          index_q <= '0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign fifo.din   = din_q;
  assign fifo.wr_en = wrEn;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_dac_word_sequencer.sv
// ----------------------------------------------------------------------------
// tb_dac_word_sequencer
//   Scoreboard bench for dac_word_sequencer (NCH=4). Stimulus pushes the
//   hand-computed words it expects into expQ; an independent monitor pops and
//   compares on every cycle where WR_EN is high. Expectations for the
//   SKIP_UNCHANGED_EN build are selected with the same macro.
// ----------------------------------------------------------------------------
module tb_dac_word_sequencer;

`ifdef SKIP_UNCHANGED_EN
  localparam bit SkipEn = 1'b1;
`else
  localparam bit SkipEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [47:0] cfgData = '0;
  logic        startReq = 1'b0;
  logic        fifoFull = 1'b0;
  logic        busy;
  logic        done;

  int checkCount = 0;
  int passCount  = 0;
  logic [15:0] expQ [$];

  dac_word_sequencer_if fifoIf ();
  assign fifoIf.full = fifoFull;

  dac_word_sequencer #(.NCH(4), .DW(12)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .cfg_data_i (cfgData),
    .start_i    (startReq),
    .busy_o     (busy),
    .done_o     (done),
    .fifo       (fifoIf)
  );

  // 100 MHz-style free-running clock
  always #5 clk = ~clk;

  // Single comparison point; every check goes through here
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Monitor: compares each FIFO write against the scoreboard head and makes
  // sure no write is issued while FULL is high
  initial begin
    logic [15:0] expWord;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (fifoFull) checkOutput("noWriteWhenFull", {31'd0, fifoIf.wr_en}, 32'd0);
        if (fifoIf.wr_en) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpectedWrite", {31'd0, fifoIf.wr_en}, 32'd0);
          end else begin
            expWord = expQ.pop_front();
            checkOutput("fifoWord", {16'd0, fifoIf.din}, {16'd0, expWord});
          end
        end
      end
    end
  end

  task automatic resetDut();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Issues START with cfg, optionally holds FULL over cycles fullFrom..fullTo
  // and pulses a second START with restartCfg at cycle restartAt (cycle 1 is
  // the first cycle after the START edge). Checks DONE latency, BUSY length,
  // DONE pulse width and that every expected word was consumed.
  task automatic applyStimulus(input string name, input logic [47:0] cfg,
                               input int fullFrom, input int fullTo,
                               input int restartAt, input logic [47:0] restartCfg,
                               input int expLat);
    int cyc;
    int busyCnt;
    bit seen;
    cfgData  = cfg;
    startReq = 1'b1;
    @(posedge clk); #1;
    cyc = 1; busyCnt = 0; seen = 1'b0;
    while (!seen && cyc <= 60) begin
      fifoFull = (cyc >= fullFrom) && (cyc <= fullTo);
      if (cyc == restartAt) begin
        startReq = 1'b1;
        cfgData  = restartCfg;
      end else begin
        startReq = 1'b0;
      end
      @(negedge clk);
      if (busy) busyCnt++;
      if (done) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    fifoFull = 1'b0;
    startReq = 1'b0;
    checkOutput({name, "_doneSeen"}, {31'd0, seen}, 32'd1);
    checkOutput({name, "_doneLatency"}, cyc, expLat);
    checkOutput({name, "_busyCycles"}, busyCnt, expLat);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput({name, "_donePulseEnds"}, {31'd0, done}, 32'd0);
    checkOutput({name, "_busyDrops"}, {31'd0, busy}, 32'd0);
    checkOutput({name, "_allWordsWritten"}, expQ.size(), 32'd0);
  endtask

  localparam logic [47:0] CfgT1  = {12'hABC, 12'h123, 12'h000, 12'hFFF};
  localparam logic [47:0] CfgT3  = {12'h444, 12'h333, 12'h222, 12'h111};
  localparam logic [47:0] CfgAlt = {12'hFED, 12'hCBA, 12'h987, 12'h654};
  localparam logic [47:0] CfgT5  = {12'hABC, 12'h456, 12'h000, 12'hFFF};

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("resetBusy", {31'd0, busy}, 32'd0);
    checkOutput("resetDone", {31'd0, done}, 32'd0);
    checkOutput("resetWrEn", {31'd0, fifoIf.wr_en}, 32'd0);
    checkOutput("resetDin", {16'd0, fifoIf.din}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // T1 basic burst (ch1 code 000 matches the reset shadow when skipping)
    $display("[TB] T1 basic burst");
    expQ.push_back(16'h0FFF);
    if (!SkipEn) expQ.push_back(16'h1000);
    expQ.push_back(16'h2123);
    expQ.push_back(16'h3ABC);
    applyStimulus("T1", CfgT1, 0, 0, 0, '0, 5);

    // T2 backpressure over cycles 2..4
    $display("[TB] T2 backpressure");
    resetDut();
    expQ.push_back(16'h0FFF);
    if (!SkipEn) expQ.push_back(16'h1000);
    expQ.push_back(16'h2123);
    expQ.push_back(16'h3ABC);
    applyStimulus("T2", CfgT1, 2, 4, 0, '0, SkipEn ? 7 : 8);

    // T3 snapshot isolation and START ignored while busy
    $display("[TB] T3 isolation");
    resetDut();
    expQ.push_back(16'h0111);
    expQ.push_back(16'h1222);
    expQ.push_back(16'h2333);
    expQ.push_back(16'h3444);
    applyStimulus("T3", CfgT3, 0, 0, 2, CfgAlt, 5);
    repeat (3) @(negedge clk);
    checkOutput("T3_noSecondBurst", {31'd0, busy}, 32'd0);

    // T4 reset after the second write
    $display("[TB] T4 reset mid-burst");
    resetDut();
    @(negedge clk);
    expQ.push_back(16'h0111);
    expQ.push_back(16'h1222);
    cfgData  = CfgT3;
    startReq = 1'b1;
    @(posedge clk); #1;
    startReq = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checkOutput("T4_resetWrEn", {31'd0, fifoIf.wr_en}, 32'd0);
    checkOutput("T4_resetBusy", {31'd0, busy}, 32'd0);
    checkOutput("T4_resetDone", {31'd0, done}, 32'd0);
    checkOutput("T4_resetDin", {16'd0, fifoIf.din}, 32'd0);
    checkOutput("T4_twoWordsWritten", expQ.size(), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    expQ.push_back(16'h0111);
    expQ.push_back(16'h1222);
    expQ.push_back(16'h2333);
    expQ.push_back(16'h3444);
    applyStimulus("T4b", CfgT3, 0, 0, 0, '0, 5);

    // T5 unchanged-channel skipping (all words written without the feature)
    $display("[TB] T5 repeated bursts");
    resetDut();
    @(negedge clk);
    expQ.push_back(16'h0FFF);
    if (!SkipEn) expQ.push_back(16'h1000);
    expQ.push_back(16'h2123);
    expQ.push_back(16'h3ABC);
    applyStimulus("T5a", CfgT1, 0, 0, 0, '0, 5);
    if (!SkipEn) begin
      expQ.push_back(16'h0FFF);
      expQ.push_back(16'h1000);
    end
    expQ.push_back(16'h2456);
    if (!SkipEn) expQ.push_back(16'h3ABC);
    applyStimulus("T5b", CfgT5, 0, 0, 0, '0, 5);
    if (!SkipEn) begin
      expQ.push_back(16'h0FFF);
      expQ.push_back(16'h1000);
      expQ.push_back(16'h2456);
      expQ.push_back(16'h3ABC);
    end
    applyStimulus("T5c", CfgT5, 0, 0, 0, '0, 5);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
